led_frame_sched: RTL and testbench
==================================

# led_frame_sched

Frame-buffer scheduler and scan sequencer for the 8×8 RGB LED matrix. It owns the green and red pixel planes and shares their single write port between two requesters, the snake game logic (port A) and the apple spawner (port B), using round-robin arbitration. It scans rows onto `data_r`/`data_g`/`data_b`/`comm`, and it double-buffers frames so the game can commit a whole move atomically at a frame boundary.

## Interface
- `SCAN_DIV`, default 10000: clk cycles per displayed row (≥2).
- `clk` in 1: system clock.
- `clear` in 1: reset; synchronous, active-high.
- `a_req` in 1: port A write request.
- `a_x`, `a_y` in 3 each: pixel row and column for port A.
- `a_layer` in 1: port A target plane, 0 = green, 1 = red.
- `a_on` in 1: port A pixel value, 1 = lit.
- `a_gnt` out 1: port A write accepted this cycle.
- `b_req`, `b_x`, `b_y`, `b_layer`, `b_on`, `b_gnt`: same as port A, for port B.
- `swap_req` in 1: level; publish the back buffer at the next frame end.
- `swap_done` out 1: one-cycle pulse on the swap edge.
- `data_r`, `data_g`, `data_b` out 8: row data, active-low (0 = lit).
- `comm` out 4: `{1'b1, row[2:0]}` row select.

## Operation
- Storage: front and back banks per plane, each 8 rows × 8 bits. A stored bit is `~on`; `x` selects the row and `y` selects the bit.
- Arbitration (combinational grant, commit on the same edge):
  - Only one requester: it is granted.
  - Both requesting: the port not granted last time wins.
  - The pointer starts favouring A after `clear`. It updates only on a grant.
  - No request: both grants are 0.
- Write target: the granted write goes to the back bank of the selected plane. The ungranted requester holds its request and data until granted.
- Scan:
  - `tick` counts 0..SCAN_DIV-1.
  - When `tick` wraps, `row` increments mod 8.
  - On that same edge, `comm`, `data_g` and `data_r` load the new row from the front banks.
  - `data_b` is constant 8'hFF.
- Swap: at the frame-end edge (`row==7` and `tick==SCAN_DIV-1`), if `swap_req`=1:
  - The front banks load the back banks. Any write granted on that edge is included.
  - The back banks keep that same content, so incremental updates continue.
  - `swap_done` pulses.
  - Outputs for row 0 on that edge already show the new front.
- `swap_req` is sampled only at frame end. A deassertion before frame end cancels the swap.

## Timing
- Reset values, applied on the edge where `clear`=1:
  - `tick`=0, `row`=0.
  - All four banks = 8'hFF.
  - `data_r`/`data_g`/`data_b` = 8'hFF, `comm` = 4'b1000.
  - `swap_done`=0; arbitration pointer favours A.
  - Grants are 0 while `clear`=1.
- `clear` overrides any in-progress frame or pending swap. No write commits on the `clear` edge.
- Grant-to-storage latency: 0 cycles. The write is visible in the back bank on the next cycle.
- Write-to-display latency:
  - With double buffering: lands in the frame following the next swap.
  - Without double buffering: appears at that row's next scan.
- Frame period: 8·SCAN_DIV cycles. `swap_done` max rate is once per frame.
- Same-pixel writes in consecutive cycles: last write wins. Writes to different planes never conflict.

## Configuration
- `LED_FRAME_DBUF_EN` defined:
  - Double buffering as described.
- `LED_FRAME_DBUF_EN` undefined:
  - Single bank per plane. Writes go directly to the displayed bank.
  - `swap_req` is still honoured only at frame end. `swap_done` pulses exactly as before, but moves no data.
  - Arbitration and scan are unchanged.

## Test plan
- Reset and scan (SCAN_DIV=4): release `clear`, run 40 cycles.
  - `comm` steps 8→9→…→F→8 every 4 cycles.
  - All data stays 8'hFF.
- Contention:
  - `a_req`=`b_req`=1 held for 4 cycles: grants go A, B, A, B.
  - Only `b_req` for 2 cycles: B, B. Then both requesting: A.
- Double buffer: port A writes green (2,5) on, no swap.
  - `data_g` stays FF for two frames.
  - Assert `swap_req`: `swap_done` pulses at frame end.
  - When `comm`=4'hA, `data_g`=8'hDF.
- Write on swap edge: port B writes red (0,0) on, granted exactly at the frame-end edge with `swap_req`=1.
  - Immediately after, `comm`=8 and `data_r`=8'hFE.
- Mid-frame clear: `clear` at row 5 with `swap_req`=1.
  - Next cycle: `comm`=8, data FF, no `swap_done`, banks all FF.
- Build without `LED_FRAME_DBUF_EN`: a green (7,0) write appears as `data_g`=8'hFE at the next `comm`=4'hF, with no swap.

Source files
------------

// File: rtl/led_frame_sched.sv
// -----------------------------------------------------------------------------
// led_frame_sched
//   Frame-buffer scheduler and scan sequencer for an 8x8 RGB LED matrix.
//   Owns the green and red pixel planes and shares their single write port
//   between two requesters (A = snake logic, B = apple spawner) with
//   round-robin arbitration. It scans one row at a time onto the active-low
//   column outputs and can optionally double-buffer frames. With double
//   buffering, a whole move is published atomically at a frame boundary.
//
// Build option:
//   LED_FRAME_DBUF_EN  defined   -> front + back bank per plane, swap at frame end
//                      undefined -> single bank per plane, written directly
//
// Parameters:
//   SCAN_DIV   clk cycles each row is displayed (>= 2)
//
// Ports:
//   clk                      system clock
//   clear                    synchronous active-high reset
//   a_req/a_x/a_y/a_layer/a_on, a_gnt
//                            write port A (x = row, y = bit, layer 0 = green,
//                            1 = red, on = lit) and its same-cycle grant
//   b_*                      same as port A, for port B
//   swap_req                 level: publish back buffer at next frame end
//   swap_done                one-cycle pulse on the swap edge
//   data_r/data_g/data_b     active-low row data (0 = lit)
//   comm                     {1'b1, row} row select
// -----------------------------------------------------------------------------
module led_frame_sched #(
    parameter int SCAN_DIV = 10000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       a_req,
    input  logic [2:0] a_x,
    input  logic [2:0] a_y,
    input  logic       a_layer,
    input  logic       a_on,
    output logic       a_gnt,
    input  logic       b_req,
    input  logic [2:0] b_x,
    input  logic [2:0] b_y,
    input  logic       b_layer,
    input  logic       b_on,
    output logic       b_gnt,
    input  logic       swap_req,
    output logic       swap_done,
    output logic [7:0] data_r,
    output logic [7:0] data_g,
    output logic [7:0] data_b,
    output logic [3:0] comm
);

    localparam int              TW        = $clog2(SCAN_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(SCAN_DIV - 1);

    logic [TW-1:0] tick_reg;
    logic [2:0]    row_reg;
    logic [2:0]    row_next;
    logic          ptr_reg;      // 1 = favour port B on the next contention
    logic          tick_wrap;
    logic          swap_fire;

    // Write-side banks: the back bank with double buffering, otherwise the
    // only (displayed) bank.
    logic [7:0]    g_wr_reg  [8];
    logic [7:0]    r_wr_reg  [8];
    logic [7:0]    g_wr_next [8];
    logic [7:0]    r_wr_next [8];

`ifdef LED_FRAME_DBUF_EN
    logic [7:0]    g_front_reg [8];
    logic [7:0]    r_front_reg [8];
`endif

    logic          wr_en;
    logic [2:0]    wr_x;
    logic [2:0]    wr_y;
    logic          wr_layer;
    logic          wr_on;
    logic [7:0]    disp_g_next;
    logic [7:0]    disp_r_next;

    // Round-robin: a lone requester always wins; on contention the pointer
    // decides. Nothing is granted while clear is asserted.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!clear) begin
            a_gnt = a_req && (!b_req || !ptr_reg);
            b_gnt = b_req && (!a_req ||  ptr_reg);
        end
    end

    always_comb begin
        wr_en    = a_gnt | b_gnt;
        wr_x     = a_gnt ? a_x     : b_x;
        wr_y     = a_gnt ? a_y     : b_y;
        wr_layer = a_gnt ? a_layer : b_layer;
        wr_on    = a_gnt ? a_on    : b_on;
    end

    // Bank contents after this edge's write, so a swap or row load on the
    // same edge already sees the granted pixel.
    always_comb begin
        g_wr_next = g_wr_reg;
        r_wr_next = r_wr_reg;
        if (wr_en) begin
            if (wr_layer)
                r_wr_next[wr_x][wr_y] = ~wr_on;
            else
                g_wr_next[wr_x][wr_y] = ~wr_on;
        end
    end

    assign tick_wrap = (tick_reg == TICK_LAST);
    assign row_next  = row_reg + 3'd1;
    assign swap_fire = tick_wrap && (row_reg == 3'd7) && swap_req;

`ifdef LED_FRAME_DBUF_EN
    // On the swap edge row 0 must already show the new front.
    always_comb begin
        disp_g_next = swap_fire ? g_wr_next[row_next] : g_front_reg[row_next];
        disp_r_next = swap_fire ? r_wr_next[row_next] : r_front_reg[row_next];
    end
`else
    always_comb begin
        disp_g_next = g_wr_next[row_next];
        disp_r_next = r_wr_next[row_next];
    end
`endif

    assign data_b = 8'hFF;

    always_ff @(posedge clk) begin
        if (clear) begin
            tick_reg  <= '0;
            row_reg   <= 3'd0;
            ptr_reg   <= 1'b0;
            swap_done <= 1'b0;
            comm      <= 4'b1000;
            data_g    <= 8'hFF;
            data_r    <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                g_wr_reg[i]    <= 8'hFF;
                r_wr_reg[i]    <= 8'hFF;
`ifdef LED_FRAME_DBUF_EN
                g_front_reg[i] <= 8'hFF;
                r_front_reg[i] <= 8'hFF;
`endif
            end
        end else begin
            g_wr_reg  <= g_wr_next;
            r_wr_reg  <= r_wr_next;
            swap_done <= swap_fire;
            if (wr_en)
                ptr_reg <= a_gnt;   // A just won -> favour B next time
            if (tick_wrap) begin
                tick_reg <= '0;
                row_reg  <= row_next;
                comm     <= {1'b1, row_next};
                data_g   <= disp_g_next;
                data_r   <= disp_r_next;
            end else begin
                tick_reg <= tick_reg + TW'(1);
            end
`ifdef LED_FRAME_DBUF_EN
            // Back banks keep their content so incremental updates continue.
            if (swap_fire) begin
                g_front_reg <= g_wr_next;
                r_front_reg <= r_wr_next;
            end
`endif
        end
    end

endmodule

// File: tb/tb_led_frame_sched.sv
module tb_led_frame_sched;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       clear;
    logic       a_req, a_layer, a_on, b_req, b_layer, b_on;
    logic [2:0] a_x, a_y, b_x, b_y;
    logic       a_gnt, b_gnt, swap_req, swap_done;
    logic [7:0] data_r, data_g, data_b;
    logic [3:0] comm;

    int checks   = 0;
    int failures = 0;
    int m_tick   = 0;
    int m_row    = 0;

    led_frame_sched #(.SCAN_DIV(DIV)) dut (
        .clk      (clk),
        .clear    (clear),
        .a_req    (a_req),
        .a_x      (a_x),
        .a_y      (a_y),
        .a_layer  (a_layer),
        .a_on     (a_on),
        .a_gnt    (a_gnt),
        .b_req    (b_req),
        .b_x      (b_x),
        .b_y      (b_y),
        .b_layer  (b_layer),
        .b_on     (b_on),
        .b_gnt    (b_gnt),
        .swap_req (swap_req),
        .swap_done(swap_done),
        .data_r   (data_r),
        .data_g   (data_g),
        .data_b   (data_b),
        .comm     (comm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; the scan position model tracks where the display should be.
    task automatic step();
        logic clr_now;
        clr_now = clear;
        @(posedge clk);
        if (clr_now) begin
            m_tick = 0;
            m_row  = 0;
        end else if (m_tick == DIV - 1) begin
            m_tick = 0;
            m_row  = (m_row + 1) % 8;
        end else begin
            m_tick++;
        end
        #1;
    endtask

    task automatic run_until(input int r, input int t);
        int n;
        n = 0;
        while (!(m_row == r && m_tick == t) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL run_until got=row%0d/tick%0d exp=row%0d/tick%0d", m_row, m_tick, r, t);
        end
    endtask

    initial begin
        clear = 1'b1; swap_req = 1'b0;
        a_req = 1'b0; a_x = 3'd0; a_y = 3'd0; a_layer = 1'b0; a_on = 1'b0;
        b_req = 1'b0; b_x = 3'd0; b_y = 3'd0; b_layer = 1'b0; b_on = 1'b0;
        step();
        step();

        // Reset state
        check("rst_comm", comm, 4'h8);
        check("rst_data_r", data_r, 8'hFF);
        check("rst_data_g", data_g, 8'hFF);
        check("rst_data_b", data_b, 8'hFF);
        check("rst_swap_done", swap_done, 1'b0);
        a_req = 1'b1; b_req = 1'b1;
        #1;
        check("rst_a_gnt", a_gnt, 1'b0);
        check("rst_b_gnt", b_gnt, 1'b0);
        step();
        a_req = 1'b0; b_req = 1'b0; clear = 1'b0;

        // Scan: comm advances every DIV cycles, data stays dark
        for (int i = 0; i < 40; i++) begin
            step();
            check("scan_comm", comm, 4'h8 | (((i + 1) / 4) % 8));
            check("scan_data_g", data_g, 8'hFF);
            check("scan_data_r", data_r, 8'hFF);
            check("scan_data_b", data_b, 8'hFF);
            check("scan_swap_done", swap_done, 1'b0);
        end

        // Contention: writes of 'off' keep the display dark
        a_x = 3'd3; a_y = 3'd3; b_x = 3'd4; b_y = 3'd4; a_on = 1'b0; b_on = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_a_gnt", a_gnt, (k % 2 == 0) ? 1'b1 : 1'b0);
            check("rr_b_gnt", b_gnt, (k % 2 == 1) ? 1'b1 : 1'b0);
            step();
        end
        a_req = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("bonly_b_gnt", b_gnt, 1'b1);
            check("bonly_a_gnt", a_gnt, 1'b0);
            step();
        end
        a_req = 1'b1;
        #1;
        check("after_b_a_gnt", a_gnt, 1'b1);
        check("after_b_b_gnt", b_gnt, 1'b0);
        a_req = 1'b0; b_req = 1'b0;
        #1;
        check("idle_a_gnt", a_gnt, 1'b0);
        check("idle_b_gnt", b_gnt, 1'b0);

        // Swap request withdrawn before frame end is cancelled
        run_until(3, 0);
        swap_req = 1'b1;
        run_until(6, 0);
        swap_req = 1'b0;
        run_until(7, 3);
        step();
        check("cancel_swap_done", swap_done, 1'b0);

`ifdef LED_FRAME_DBUF_EN
        // Green (2,5) written to back bank only
        a_req = 1'b1; a_x = 3'd2; a_y = 3'd5; a_layer = 1'b0; a_on = 1'b1;
        #1;
        check("dbuf_a_gnt", a_gnt, 1'b1);
        step();
        a_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            check("dbuf_hold_g", data_g, 8'hFF);
        end
        swap_req = 1'b1;
        run_until(7, 3);
        step();
        check("dbuf_swap_done", swap_done, 1'b1);
        check("dbuf_swap_comm", comm, 4'h8);
        swap_req = 1'b0;
        step();
        check("dbuf_swap_pulse_end", swap_done, 1'b0);
        run_until(2, 0);
        check("dbuf_row2_comm", comm, 4'hA);
        check("dbuf_row2_g", data_g, 8'hDF);
        check("dbuf_row2_r", data_r, 8'hFF);

        // Red (0,0) granted exactly on the swap edge
        run_until(7, 3);
        b_req = 1'b1; b_x = 3'd0; b_y = 3'd0; b_layer = 1'b1; b_on = 1'b1;
        swap_req = 1'b1;
        #1;
        check("edge_b_gnt", b_gnt, 1'b1);
        step();
        b_req = 1'b0; swap_req = 1'b0;
        check("edge_comm", comm, 4'h8);
        check("edge_data_r", data_r, 8'hFE);
        check("edge_data_g", data_g, 8'hFF);
        check("edge_swap_done", swap_done, 1'b1);

        // Mid-frame clear with a pending swap
        run_until(5, 1);
        swap_req = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0;
        check("mclr_comm", comm, 4'h8);
        check("mclr_data_r", data_r, 8'hFF);
        check("mclr_data_g", data_g, 8'hFF);
        check("mclr_swap_done", swap_done, 1'b0);
        // Swapping the cleared back banks in must show a dark frame
        run_until(7, 3);
        step();
        check("mclr_swap_done2", swap_done, 1'b1);
        swap_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("mclr_bank_r", data_r, 8'hFF);
            check("mclr_bank_g", data_g, 8'hFF);
            step();
        end
`else
        // Single bank: green (7,0) shows at the next scan of row 7
        run_until(1, 0);
        a_req = 1'b1; a_x = 3'd7; a_y = 3'd0; a_layer = 1'b0; a_on = 1'b1;
        #1;
        check("sb_a_gnt", a_gnt, 1'b1);
        step();
        a_req = 1'b0;
        run_until(6, 0);
        check("sb_row6_g", data_g, 8'hFF);
        run_until(7, 0);
        check("sb_row7_comm", comm, 4'hF);
        check("sb_row7_g", data_g, 8'hFE);
        check("sb_row7_swap_done", swap_done, 1'b0);

        // swap_done still pulses, moving no data
        swap_req = 1'b1;
        run_until(7, 3);
        step();
        check("sb_swap_done", swap_done, 1'b1);
        check("sb_swap_comm", comm, 4'h8);
        check("sb_swap_r", data_r, 8'hFF);
        swap_req = 1'b0;
        step();
        check("sb_swap_pulse_end", swap_done, 1'b0);

        // Red (0,0) written late in row 7 appears on row 0
        run_until(7, 1);
        b_req = 1'b1; b_x = 3'd0; b_y = 3'd0; b_layer = 1'b1; b_on = 1'b1;
        #1;
        check("sb_b_gnt", b_gnt, 1'b1);
        step();
        b_req = 1'b0;
        run_until(0, 0);
        check("sb_row0_comm", comm, 4'h8);
        check("sb_row0_r", data_r, 8'hFE);

        // Mid-frame clear with a pending swap
        run_until(5, 1);
        swap_req = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; swap_req = 1'b0;
        check("mclr_comm", comm, 4'h8);
        check("mclr_data_r", data_r, 8'hFF);
        check("mclr_data_g", data_g, 8'hFF);
        check("mclr_swap_done", swap_done, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step();
            check("mclr_bank_r", data_r, 8'hFF);
            check("mclr_bank_g", data_g, 8'hFF);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
